// File: rtl/mode_hub_pkg.sv
// mode_hub_pkg: shared types and helpers for the front-panel controller.
//   hub_state_t : OFF / MENU / ACTIVE operating states
//   BLANK       : segment pattern for an unlit digit
//   glyph()     : seven-segment pattern for a decimal digit,
//                 bit7=a .. bit1=g, bit0=dp, active-high
package mode_hub_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    MENU   = 2'd1,
    ACTIVE = 2'd2
  } hub_state_t;

  localparam logic [7:0] BLANK = 8'h00;

  function automatic logic [7:0] glyph(input logic [3:0] digit);
    logic [7:0] pat;
    case (digit)
      4'd0:    pat = 8'b1111_1100;
      4'd1:    pat = 8'b0110_0000;
      4'd2:    pat = 8'b1101_1010;
      4'd3:    pat = 8'b1111_0010;
      4'd4:    pat = 8'b0110_0110;
      4'd5:    pat = 8'b1011_0110;
      4'd6:    pat = 8'b1011_1110;
      4'd7:    pat = 8'b1110_0000;
      4'd8:    pat = 8'b1111_1110;
      4'd9:    pat = 8'b1111_0110;
      default: pat = BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/mode_hub_if.sv
// mode_hub_if: bundle between the hub, the application blocks and the panel.
//   mode_seg    : per-mode digit patterns, mode m digit d at [(m*N_DIGITS+d)*8 +: 8]
//   mode_leds   : per-mode LED patterns, mode m at [m*8 +: 8]
//   mode_busy   : mode m is inside its own sub-menu (blocks exit)
//   mode_sel    : one-hot selected mode
//   mode_active : hub is in ACTIVE
//   powered     : hub is not in OFF
//   seg_a/seg_b : lower/upper display bank segment data
//   anode       : one-hot digit enable
//   leds        : LED output
// master = hub side, slave = application/panel side.
interface mode_hub_if #(
  parameter int N_MODES  = 4,
  parameter int N_DIGITS = 8
);
  logic [N_MODES*N_DIGITS*8-1:0] mode_seg;
  logic [N_MODES*8-1:0]          mode_leds;
  logic [N_MODES-1:0]            mode_busy;
  logic [N_MODES-1:0]            mode_sel;
  logic                          mode_active;
  logic                          powered;
  logic [7:0]                    seg_a;
  logic [7:0]                    seg_b;
  logic [N_DIGITS-1:0]           anode;
  logic [7:0]                    leds;

  modport master (
    input  mode_seg, mode_leds, mode_busy,
    output mode_sel, mode_active, powered, seg_a, seg_b, anode, leds
  );

  modport slave (
    output mode_seg, mode_leds, mode_busy,
    input  mode_sel, mode_active, powered, seg_a, seg_b, anode, leds
  );
endinterface

// File: rtl/mode_hub_button_conditioner.sv
// button_conditioner: synchroniser, debounce filter and press detector for
// one raw asynchronous active-high button.
//   clk, reset : system clock, synchronous active-high reset
//   btn        : raw button level
//   press      : one-cycle pulse when the debounced level rises
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      // stage p0 -> p1: two-flop synchroniser
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      // stage p1 -> level: count consecutive cycles of disagreement
      press   <= 1'b0;
      if (sync_p1 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync_p1;
          cnt   <= '0;
          // only a rising stable level is a press; release is silent
          press <= sync_p1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mode_hub.sv
// mode_hub: front-panel controller. Debounces the power/confirm/select/exit
// buttons, runs the OFF/MENU/ACTIVE mode machine over N_MODES one-hot modes
// and drives the time-multiplexed two-bank seven-segment display.
//   clk, reset                          : system clock, sync active-high reset
//   power_button, confirm, select, exit : raw asynchronous buttons
//   bus (mode_hub_if.master)            : mode buffers in, selection/display out
module mode_hub
  import mode_hub_pkg::*;
#(
  parameter int N_MODES         = 4,
  parameter int N_DIGITS        = 8,
  parameter int SCAN_CYCLES     = 100000,
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        power_button,
  input  logic        confirm,
  input  logic        select,
  input  logic        exit,
  mode_hub_if.master  bus
);

  localparam int SW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = $clog2(N_DIGITS);
  localparam int IW = $clog2(N_MODES);

  logic pwr_ev, cfm_ev, sel_ev, ext_ev;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pwr (
    .clk(clk), .reset(reset), .btn(power_button), .press(pwr_ev));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cfm (
    .clk(clk), .reset(reset), .btn(confirm), .press(cfm_ev));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel (
    .clk(clk), .reset(reset), .btn(select), .press(sel_ev));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ext (
    .clk(clk), .reset(reset), .btn(exit), .press(ext_ev));

  // ---- scan timing: slot counter and current digit ----
  logic [SW-1:0] slot;
  logic [DW-1:0] digit;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot  <= '0;
      digit <= '0;
    end else if (slot == SW'(SCAN_CYCLES - 1)) begin
      slot  <= '0;
      digit <= (digit == DW'(N_DIGITS - 1)) ? '0 : digit + 1'b1;
    end else begin
      slot <= slot + 1'b1;
    end
  end

  // ---- mode state machine ----
  hub_state_t         state;
  logic [N_MODES-1:0] sel_q;
  logic               active_q;
  logic               powered_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OFF;
      sel_q     <= N_MODES'(1);
      active_q  <= 1'b0;
      powered_q <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          if (pwr_ev) begin
            state     <= MENU;
            powered_q <= 1'b1;
          end
        end
        MENU: begin
          // exit has no meaning here, so confirm is the next candidate
          if (pwr_ev) begin
            state     <= OFF;
            powered_q <= 1'b0;
          end else if (cfm_ev) begin
            state    <= ACTIVE;
            active_q <= 1'b1;
          end else if (sel_ev) begin
            sel_q <= {sel_q[N_MODES-2:0], sel_q[N_MODES-1]};
          end
        end
        ACTIVE: begin
          // select/confirm belong to the running mode block
          if (pwr_ev) begin
            state     <= OFF;
            active_q  <= 1'b0;
            powered_q <= 1'b0;
          end else if (ext_ev && ((bus.mode_busy & sel_q) == '0)) begin
            state    <= MENU;
            active_q <= 1'b0;
          end
        end
        default: begin
          state     <= OFF;
          active_q  <= 1'b0;
          powered_q <= 1'b0;
        end
      endcase
    end
  end

  // ---- display content for the digit being scanned ----
  logic [IW-1:0] sel_idx;
  logic [7:0]    content;
  logic [7:0]    leds_d;
  logic          lower_bank;

  always_comb begin
    sel_idx = '0;
    for (int m = 0; m < N_MODES; m++) begin
      if (sel_q[m]) sel_idx = IW'(m);
    end
  end

  always_comb begin
    content = BLANK;
    leds_d  = BLANK;
    case (state)
      MENU: begin
        if (digit == '0) content = glyph(4'(sel_idx) + 4'd1);
      end
      ACTIVE: begin
        content = bus.mode_seg[(int'(sel_idx) * N_DIGITS + int'(digit)) * 8 +: 8];
        leds_d  = bus.mode_leds[int'(sel_idx) * 8 +: 8];
      end
      default: begin
        content = BLANK;
        leds_d  = BLANK;
      end
    endcase
  end

  assign lower_bank = (digit < DW'(N_DIGITS / 2));

  // ---- registered display outputs ----
  logic [7:0]          seg_a_q;
  logic [7:0]          seg_b_q;
  logic [N_DIGITS-1:0] anode_q;
  logic [7:0]          leds_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_a_q <= BLANK;
      seg_b_q <= BLANK;
      anode_q <= '0;
      leds_q  <= BLANK;
    end else begin
      // the idle bank is forced blank so it never shows a stale digit
      seg_a_q <= lower_bank ? content : BLANK;
      seg_b_q <= lower_bank ? BLANK : content;
      anode_q <= (state != OFF) ? (N_DIGITS'(1) << digit) : '0;
      leds_q  <= leds_d;
    end
  end

  assign bus.mode_sel    = sel_q;
  assign bus.mode_active = active_q;
  assign bus.powered     = powered_q;
  assign bus.seg_a       = seg_a_q;
  assign bus.seg_b       = seg_b_q;
  assign bus.anode       = anode_q;
  assign bus.leds        = leds_q;

endmodule

// File: tb/tb_mode_hub.sv
// tb_mode_hub: directed plus randomized bench for mode_hub with a behavioural
// model of the mode rules and the display scan.
module tb_mode_hub;

  localparam int NM = 4;
  localparam int ND = 8;
  localparam int SC = 3;
  localparam int DC = 4;

  localparam int S_OFF  = 0;
  localparam int S_MENU = 1;
  localparam int S_ACT  = 2;

  logic clk = 1'b0;
  logic reset;
  logic power_button, confirm, select, exit;

  mode_hub_if #(.N_MODES(NM), .N_DIGITS(ND)) bus ();

  mode_hub #(
    .N_MODES(NM), .N_DIGITS(ND), .SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .power_button(power_button), .confirm(confirm),
    .select(select), .exit(exit), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc;

  // edges since reset release
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  logic [7:0] glyph_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  int m_state;
  int m_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void apply(input bit p, input bit c, input bit s, input bit e);
    if (p) begin
      m_state = (m_state == S_OFF) ? S_MENU : S_OFF;
    end else if (m_state == S_ACT) begin
      if (e && !bus.mode_busy[m_idx]) m_state = S_MENU;
    end else if (m_state == S_MENU) begin
      if (c)      m_state = S_ACT;
      else if (s) m_idx = (m_idx + 1) % NM;
    end
  endfunction

  // clean simultaneous press of the chosen buttons, then release and settle
  task automatic press(input bit p, input bit c, input bit s, input bit e, input int hold);
    power_button = p; confirm = c; select = s; exit = e;
    tick(hold);
    power_button = 0; confirm = 0; select = 0; exit = 0;
    tick(14);
    apply(p, c, s, e);
  endtask

  task automatic check_scan(input int n);
    int d;
    logic [7:0] content, eleds;
    logic [ND-1:0] ean;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d = ((cyc - 1) / SC) % ND;
      content = 8'h00; eleds = 8'h00; ean = '0;
      if (m_state == S_MENU) begin
        ean = ND'(1) << d;
        if (d == 0) content = glyph_tab[m_idx + 1];
      end else if (m_state == S_ACT) begin
        ean = ND'(1) << d;
        content = bus.mode_seg[(m_idx * ND + d) * 8 +: 8];
        eleds = bus.mode_leds[m_idx * 8 +: 8];
      end
      chk("mode_sel", 32'(bus.mode_sel), 32'(1 << m_idx));
      chk("mode_active", 32'(bus.mode_active), 32'(m_state == S_ACT));
      chk("powered", 32'(bus.powered), 32'(m_state != S_OFF));
      chk("anode", 32'(bus.anode), 32'(ean));
      chk("seg_a", 32'(bus.seg_a), 32'((d < ND / 2) ? content : 8'h00));
      chk("seg_b", 32'(bus.seg_b), 32'((d < ND / 2) ? 8'h00 : content));
      chk("leds", 32'(bus.leds), 32'(eleds));
    end
  endtask

  task automatic randomize_buffers();
    for (int w = 0; w < NM * ND * 8 / 32; w++) bus.mode_seg[w * 32 +: 32] = $urandom();
    bus.mode_leds = $urandom();
  endtask

  initial begin
    power_button = 0; confirm = 0; select = 0; exit = 0;
    bus.mode_busy = '0;
    randomize_buffers();
    m_state = S_OFF;
    m_idx   = 0;

    // reset state
    reset = 1;
    tick(3);
    @(negedge clk);
    chk("rst_mode_sel", 32'(bus.mode_sel), 32'h1);
    chk("rst_active", 32'(bus.mode_active), 32'h0);
    chk("rst_powered", 32'(bus.powered), 32'h0);
    chk("rst_seg_a", 32'(bus.seg_a), 32'h0);
    chk("rst_seg_b", 32'(bus.seg_b), 32'h0);
    chk("rst_anode", 32'(bus.anode), 32'h0);
    chk("rst_leds", 32'(bus.leds), 32'h0);
    @(posedge clk); #1;
    reset = 0;
    check_scan(6);

    // power on, with a latency window check on powered
    power_button = 1;
    tick(5);
    chk("pwr_early", 32'(bus.powered), 32'h0);
    tick(3);
    chk("pwr_late", 32'(bus.powered), 32'h1);
    tick(2);
    power_button = 0;
    tick(14);
    apply(1, 0, 0, 0);
    check_scan(ND * SC + 3);

    // select wrap through all modes
    for (int i = 0; i < NM; i++) begin
      press(0, 0, 1, 0, 10);
      check_scan(ND * SC);
    end

    // bouncing select never holds long enough
    for (int i = 0; i < 5; i++) begin
      select = 1; tick(2);
      select = 0; tick(2);
    end
    tick(14);
    check_scan(6);

    // enter mode 2, blocked exit, real exit
    press(0, 0, 1, 0, 10);
    press(0, 0, 1, 0, 10);
    press(0, 1, 0, 0, 10);
    check_scan(ND * SC);
    bus.mode_busy = 4'b0100;
    press(0, 0, 0, 1, 10);
    check_scan(6);
    bus.mode_busy = 4'b0000;
    press(0, 0, 0, 1, 10);
    check_scan(6);

    // power and confirm together in MENU
    press(1, 1, 0, 0, 10);
    check_scan(ND * SC);

    // button held across reset yields one press after release
    power_button = 1;
    tick(3);
    reset = 1;
    tick(3);
    reset = 0;
    m_state = S_OFF;
    m_idx   = 0;
    tick(10);
    power_button = 0;
    tick(14);
    apply(1, 0, 0, 0);
    check_scan(ND * SC);

    // randomized button combinations against the model
    for (int step = 0; step < 60; step++) begin
      bit p, c, s, e;
      int hold;
      randomize_buffers();
      bus.mode_busy = NM'($urandom_range(0, 15));
      p = ($urandom_range(0, 5) == 0);
      c = $urandom_range(0, 1) == 1;
      s = $urandom_range(0, 1) == 1;
      e = $urandom_range(0, 1) == 1;
      hold = $urandom_range(8, 14);
      tick(2);
      press(p, c, s, e, hold);
      check_scan($urandom_range(4, ND * SC));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
